// File: rtl/branch_pkg.sv
// Shared constants and types for the branch execution unit.
// Holds funct3 encodings, FSM state type and the fall-through PC step.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CMP,
    S_DONE
  } br_state_t;

endpackage

// File: rtl/branch_exec_unit_if.sv
// Handshake bus of the branch unit: instruction in, register write, result out.
// master drives instruction/write/out_ready; slave (the unit) drives the rest.
interface branch_exec_unit_if #(
  parameter int XLEN  = 64,
  parameter int PC_W  = 32,
  parameter int NREG  = 32,
  parameter int IMM_W = 12
);
  localparam int RW = $clog2(NREG);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       funct3;
  logic [RW-1:0]    rs1;
  logic [RW-1:0]    rs2;
  logic [IMM_W-1:0] imm;
  logic [PC_W-1:0]  pc;
  logic             wr_en;
  logic [RW-1:0]    wr_addr;
  logic [XLEN-1:0]  wr_data;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  npc;
  logic             taken;
  logic             illegal;
  logic             misaligned;

  modport master (
    output in_valid, funct3, rs1, rs2, imm, pc,
    output wr_en, wr_addr, wr_data, out_ready,
    input  in_ready, out_valid, npc, taken,
    input  illegal, misaligned
  );

  modport slave (
    input  in_valid, funct3, rs1, rs2, imm, pc,
    input  wr_en, wr_addr, wr_data, out_ready,
    output in_ready, out_valid, npc, taken,
    output illegal, misaligned
  );

endinterface

// File: rtl/branch_cmp.sv
// Combinational branch comparator: a, b, funct3 -> taken, illegal.
// Non-branch funct3 codes flag illegal and never report taken.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  output logic            taken,
  output logic            illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    unique case (1'b1)
      (funct3 == F3_BEQ):  taken = (a == b);
      (funct3 == F3_BNE):  taken = (a != b);
      (funct3 == F3_BLT):  taken = ($signed(a) < $signed(b));
      (funct3 == F3_BGE):  taken = ($signed(a) >= $signed(b));
      (funct3 == F3_BLTU): taken = (a < b);
      (funct3 == F3_BGEU): taken = (a >= b);
      default:             illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_exec_unit.sv
// Multi-cycle branch unit: local regfile, IDLE->READ->CMP->DONE FSM.
// Ports: clk, rst_n (sync, active-low), bus (slave); with
// BRANCH_EXEC_STATS_EN also br_total/br_taken saturating counters.
module branch_exec_unit
  import branch_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int PC_W  = 32,
  parameter int NREG  = 32,
  parameter int IMM_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_exec_unit_if.slave  bus
`ifdef BRANCH_EXEC_STATS_EN
  ,
  output logic [31:0]        br_total,
  output logic [31:0]        br_taken
`endif
);

  localparam int RW = $clog2(NREG);

  br_state_t        state;
  logic [XLEN-1:0]  rf [NREG];
  logic [2:0]       f3_q;
  logic [RW-1:0]    rs1_q;
  logic [RW-1:0]    rs2_q;
  logic [IMM_W-1:0] imm_q;
  logic [PC_W-1:0]  pc_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [XLEN-1:0]  a_rd;
  logic [XLEN-1:0]  b_rd;
  logic [PC_W-1:0]  npc_q;
  logic             taken_q;
  logic             illegal_q;
  logic             mis_q;
  logic             cmp_taken;
  logic             cmp_illegal;
  logic [PC_W-1:0]  imm_ext;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  fall;

  // Same-cycle write wins over the stored value; x0 is hardwired zero.
  always_comb begin
    a_rd = rf[rs1_q];
    if (bus.wr_en && bus.wr_addr == rs1_q) a_rd = bus.wr_data;
    if (rs1_q == '0) a_rd = '0;
    b_rd = rf[rs2_q];
    if (bus.wr_en && bus.wr_addr == rs2_q) b_rd = bus.wr_data;
    if (rs2_q == '0) b_rd = '0;
  end

  assign imm_ext = PC_W'($signed(imm_q));
  assign target  = pc_q + {imm_ext[PC_W-2:0], 1'b0};
  assign fall    = pc_q + PC_W'(PC_STEP);

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .a       (a_q),
    .b       (b_q),
    .funct3  (f3_q),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= (i < NREG / 2) ? XLEN'(i) : XLEN'(NREG - i);
    end else if (bus.wr_en && bus.wr_addr != '0) begin
      rf[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      f3_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      npc_q     <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            f3_q  <= bus.funct3;
            rs1_q <= bus.rs1;
            rs2_q <= bus.rs2;
            imm_q <= bus.imm;
            pc_q  <= bus.pc;
            state <= S_READ;
          end
        end
        S_READ: begin
          a_q   <= a_rd;
          b_q   <= b_rd;
          state <= S_CMP;
        end
        S_CMP: begin
          taken_q   <= cmp_taken;
          illegal_q <= cmp_illegal;
          npc_q     <= cmp_taken ? target : fall;
          mis_q     <= cmp_taken & target[1];
          state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == S_IDLE);
  assign bus.out_valid  = (state == S_DONE);
  assign bus.npc        = npc_q;
  assign bus.taken      = taken_q;
  assign bus.illegal    = illegal_q;
  assign bus.misaligned = mis_q;

`ifdef BRANCH_EXEC_STATS_EN
  logic hs;
  assign hs = (state == S_DONE) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_total <= '0;
      br_taken <= '0;
    end else if (hs) begin
      if (br_total != '1) br_total <= br_total + 32'd1;
      if (taken_q && br_taken != '1) br_taken <= br_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_exec_unit.sv
// Self-checking bench for branch_exec_unit: vector table, hand sequences,
// and random branches against a behavioural reference model.
module tb_branch_exec_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_exec_unit_if bus ();

`ifdef BRANCH_EXEC_STATS_EN
  logic [31:0] br_total;
  logic [31:0] br_taken;
`endif

  branch_exec_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef BRANCH_EXEC_STATS_EN
    ,
    .br_total (br_total),
    .br_taken (br_taken)
`endif
  );

  typedef struct {
    logic [2:0]  f3;
    int          rs1;
    int          rs2;
    logic [11:0] imm;
    logic [31:0] pc;
    bit          pre_wr;
    int          wa;
    logic [63:0] wd;
    logic [31:0] e_npc;
    bit          e_tk;
    bit          e_il;
    bit          e_mis;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int hs_total = 0;
  int hs_taken = 0;
  logic [63:0] mregs [32];

  function automatic vec_t mkv(
    input logic [2:0] f3, input int r1, input int r2,
    input logic [11:0] imm, input logic [31:0] pc,
    input bit pw, input int wa, input logic [63:0] wd,
    input logic [31:0] enpc, input bit etk, input bit eil, input bit emis);
    vec_t v;
    v.f3 = f3; v.rs1 = r1; v.rs2 = r2; v.imm = imm; v.pc = pc;
    v.pre_wr = pw; v.wa = wa; v.wd = wd;
    v.e_npc = enpc; v.e_tk = etk; v.e_il = eil; v.e_mis = emis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++)
      mregs[i] = (i < 16) ? 64'(i) : 64'(32 - i);
    hs_total = 0;
    hs_taken = 0;
  endtask

  function automatic logic [63:0] mrd(input int idx);
    return (idx == 0) ? 64'd0 : mregs[idx];
  endfunction

  // Reference: plain arithmetic on the branch rules.
  task automatic ref_br(input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] b, input logic [11:0] imm,
                        input logic [31:0] pc, output logic [31:0] npc,
                        output bit tk, output bit il, output bit mis);
    longint off;
    longint t;
    longint f;
    off = longint'(imm);
    if (off >= 2048) off = off - 4096;
    t = (longint'(pc) + off * 2) & 64'hFFFF_FFFF;
    f = (longint'(pc) + 4) & 64'hFFFF_FFFF;
    tk = 0;
    il = 0;
    case (f3)
      3'd0: tk = (a == b);
      3'd1: tk = (a != b);
      3'd4: tk = ($signed(a) < $signed(b));
      3'd5: tk = ($signed(a) >= $signed(b));
      3'd6: tk = (a < b);
      3'd7: tk = (a >= b);
      default: il = 1;
    endcase
    npc = tk ? 32'(t) : 32'(f);
    mis = tk && (((t >> 1) & 1) == 1);
  endtask

  task automatic write_reg(input int a, input logic [63:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_addr = 5'(a);
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (a != 0) mregs[a] = d;
  endtask

  task automatic issue(
    input logic [2:0] f3, input int r1, input int r2,
    input logic [11:0] imm, input logic [31:0] pc,
    input bit fwd, input int fa, input logic [63:0] fd, input bit noise,
    output logic [31:0] onpc, output bit otk, output bit oil,
    output bit omis);
    int cnt;
    @(negedge clk);
    cnt = 0;
    while (!bus.in_ready && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.funct3 = f3;
    bus.rs1 = 5'(r1);
    bus.rs2 = 5'(r2);
    bus.imm = imm;
    bus.pc = pc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (fwd) begin
      bus.wr_en = 1'b1;
      bus.wr_addr = 5'(fa);
      bus.wr_data = fd;
      if (fa != 0) mregs[fa] = fd;
    end
    cnt = 1;
    while (!bus.out_valid && cnt < 12) begin
      @(negedge clk);
      bus.wr_en = 1'b0;
      if (noise) bus.out_ready = 1'($urandom);
      cnt++;
    end
    bus.wr_en = 1'b0;
    bus.out_ready = 1'b0;
    chk("latency", 64'(cnt), 64'd3);
    onpc = bus.npc;
    otk = bus.taken;
    oil = bus.illegal;
    omis = bus.misaligned;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    hs_total++;
    if (otk) hs_taken++;
    chk("out_valid_drop", 64'(bus.out_valid), 64'd0);
  endtask

  vec_t tbl [10];

  initial begin
    logic [31:0] g_npc;
    logic [31:0] e_npc;
    logic [31:0] cap;
    bit g_tk, g_il, g_mis, e_tk, e_il, e_mis, ok;
    int cnt;

    bus.in_valid = 0; bus.funct3 = 0; bus.rs1 = 0; bus.rs2 = 0;
    bus.imm = 0; bus.pc = 0; bus.wr_en = 0; bus.wr_addr = 0;
    bus.wr_data = 0; bus.out_ready = 0;

    tbl[0] = mkv(3'b000, 5, 27, 12'd8, 32'h100, 0, 0, 0,
                 32'h110, 1, 0, 0);
    tbl[1] = mkv(3'b100, 3, 1, 12'h10, 32'h200, 1, 3, '1,
                 32'h220, 1, 0, 0);
    tbl[2] = mkv(3'b110, 3, 1, 12'h10, 32'h200, 0, 0, 0,
                 32'h204, 0, 0, 0);
    tbl[3] = mkv(3'b001, 2, 30, 12'd4, 32'hFFFF_FFFC, 0, 0, 0,
                 32'h0, 0, 0, 0);
    tbl[4] = mkv(3'b000, 2, 30, 12'hFFF, 32'h10, 0, 0, 0,
                 32'hE, 1, 0, 1);
    tbl[5] = mkv(3'b010, 1, 2, 12'd4, 32'h40, 0, 0, 0,
                 32'h44, 0, 1, 0);
    tbl[6] = mkv(3'b000, 0, 0, 12'd1, 32'h0, 0, 0, 0,
                 32'h2, 1, 0, 1);
    tbl[7] = mkv(3'b101, 3, 1, 12'd8, 32'h300, 0, 0, 0,
                 32'h304, 0, 0, 0);
    tbl[8] = mkv(3'b111, 3, 1, 12'd8, 32'h300, 0, 0, 0,
                 32'h310, 1, 0, 0);
    tbl[9] = mkv(3'b011, 7, 7, 12'd0, 32'h80, 0, 0, 0,
                 32'h84, 0, 1, 0);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_npc", 64'(bus.npc), 64'd0);
    chk("rst_flags", {61'd0, bus.taken, bus.illegal, bus.misaligned}, 64'd0);
`ifdef BRANCH_EXEC_STATS_EN
    chk("rst_stats", {br_total, br_taken}, 64'd0);
`endif

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].pre_wr) write_reg(tbl[i].wa, tbl[i].wd);
      issue(tbl[i].f3, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].pc,
            0, 0, 0, 0, g_npc, g_tk, g_il, g_mis);
      chk($sformatf("vec%0d_npc", i), 64'(g_npc), 64'(tbl[i].e_npc));
      chk($sformatf("vec%0d_flags", i), {61'd0, g_tk, g_il, g_mis},
          {61'd0, tbl[i].e_tk, tbl[i].e_il, tbl[i].e_mis});
    end

    // Stall in DONE with a competing request offered.
    @(negedge clk);
    bus.in_valid = 1; bus.funct3 = 3'b000; bus.rs1 = 5; bus.rs2 = 27;
    bus.imm = 12'd8; bus.pc = 32'h100;
    @(negedge clk);
    bus.in_valid = 0;
    cnt = 1;
    while (!bus.out_valid && cnt < 12) begin
      @(negedge clk);
      cnt++;
    end
    chk("stall_latency", 64'(cnt), 64'd3);
    cap = bus.npc;
    chk("stall_npc", 64'(cap), 64'h110);
    bus.in_valid = 1; bus.funct3 = 3'b001; bus.pc = 32'h900;
    ok = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.npc !== cap || bus.out_valid !== 1 || bus.in_ready !== 0 ||
          bus.taken !== 1) ok = 0;
    end
    chk("stall_stable", 64'(ok), 64'd1);
    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 0;
    bus.out_ready = 1;
    @(negedge clk);
    bus.out_ready = 0;
    hs_total++;
    hs_taken++;
    chk("stall_release", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);

    // Forwarding: write reg4=9 in the READ cycle.
    issue(3'b000, 4, 9, 12'd16, 32'h400, 1, 4, 64'd9, 0,
          g_npc, g_tk, g_il, g_mis);
    chk("fwd_taken", 64'(g_tk), 64'd1);
    chk("fwd_npc", 64'(g_npc), 64'h420);

    for (int n = 0; n < 60; n++) begin
      int r1, r2, wa;
      logic [2:0] f3;
      logic [11:0] imm;
      logic [31:0] pc;
      if ($urandom_range(1, 0) == 1) begin
        wa = $urandom_range(31, 0);
        if ($urandom_range(1, 0) == 1)
          write_reg(wa, {$urandom, $urandom});
        else
          write_reg(wa, 64'($urandom_range(40, 0)));
      end
      f3 = 3'($urandom);
      r1 = $urandom_range(31, 0);
      r2 = $urandom_range(31, 0);
      imm = 12'($urandom);
      pc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15, 0))
                                        : $urandom;
      ref_br(f3, mrd(r1), mrd(r2), imm, pc, e_npc, e_tk, e_il, e_mis);
      issue(f3, r1, r2, imm, pc, 0, 0, 0, 1, g_npc, g_tk, g_il, g_mis);
      chk($sformatf("rnd%0d_npc", n), 64'(g_npc), 64'(e_npc));
      chk($sformatf("rnd%0d_flags", n), {61'd0, g_tk, g_il, g_mis},
          {61'd0, e_tk, e_il, e_mis});
    end

    // Reset while in CMP aborts the instruction.
    write_reg(3, 64'hDEAD);
    @(negedge clk);
    bus.in_valid = 1; bus.funct3 = 3'b000; bus.rs1 = 5; bus.rs2 = 27;
    bus.imm = 12'd8; bus.pc = 32'h100;
    @(negedge clk);
    bus.in_valid = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    chk("abort_state", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);
    chk("abort_npc", 64'(bus.npc), 64'd0);
    ok = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.out_valid !== 0) ok = 0;
    end
    chk("abort_no_valid", 64'(ok), 64'd1);

    issue(3'b000, 5, 27, 12'd8, 32'h100, 0, 0, 0, 0,
          g_npc, g_tk, g_il, g_mis);
    chk("post_rst_beq", {31'd0, g_npc, g_tk}, {31'd0, 32'h110, 1'b1});
    issue(3'b001, 3, 1, 12'd8, 32'h500, 0, 0, 0, 0,
          g_npc, g_tk, g_il, g_mis);
    chk("post_rst_bne", {31'd0, g_npc, g_tk}, {31'd0, 32'h510, 1'b1});
    issue(3'b100, 3, 1, 12'd8, 32'h500, 0, 0, 0, 0,
          g_npc, g_tk, g_il, g_mis);
    chk("post_rst_blt", {31'd0, g_npc, g_tk}, {31'd0, 32'h504, 1'b0});
`ifdef BRANCH_EXEC_STATS_EN
    chk("stats_total", 64'(br_total), 64'd3);
    chk("stats_taken", 64'(br_taken), 64'd2);
    chk("stats_model", {br_total, br_taken},
        {32'(hs_total), 32'(hs_taken)});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_exec_unit.md
# branch_exec_unit

Parametrised, multi-cycle conditional-branch execution unit. It holds a local register file and accepts one branch instruction per valid/ready transaction. It compares two registers under any RV-style branch condition and returns the next program counter and a taken flag through an output handshake. It sits between decode and the PC update logic and generalises the single-condition BEQ datapath to six conditions, configurable widths and backpressure.

## Interface
Parameters:
- XLEN, 64: register/operand width
- PC_W, 32: program counter width
- NREG, 32: register count (power of two, ≥4); index width RW = $clog2(NREG)
- IMM_W, 12: branch immediate width (offset in half-words)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  unit can accept
- funct3  in  3  branch condition
- rs1, rs2  in  RW  source register indices
- imm  in  IMM_W  signed branch immediate
- pc  in  PC_W  PC of the branch
- wr_en  in  1  register write strobe
- wr_addr  in  RW  write index
- wr_data  in  XLEN  write data
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- npc  out  PC_W  next PC
- taken  out  1  branch taken
- illegal  out  1  funct3 not a branch encoding
- misaligned  out  1  taken target not 4-byte aligned

## Operation
- FSM states: IDLE → READ → CMP → DONE → IDLE.
- IDLE: in_ready=1. On in_valid, the unit latches funct3, rs1, rs2, imm and pc, then moves to READ.
- READ: the unit latches a=reg[rs1] and b=reg[rs2]. A same-cycle wr_en to rs1/rs2 is forwarded, so the latched value is wr_data. Register 0 always reads 0.
- CMP: the unit evaluates the condition and registers npc, taken, illegal and misaligned.
  - 000 BEQ a==b
  - 001 BNE a!=b
  - 100 BLT signed a<b
  - 101 BGE signed a>=b
  - 110 BLTU unsigned a<b
  - 111 BGEU unsigned a>=b
  - 010/011: illegal=1, taken=0
- Target = pc + (sign_extend(imm) << 1), computed modulo 2^PC_W. Fall-through = pc + 4, also modulo 2^PC_W.
- npc = taken ? target : fall-through.
- misaligned = taken & target[1]. npc still equals target; the flag is reported only.
- DONE: out_valid=1 and outputs are held stable until out_ready. When out_valid&out_ready, the unit returns to IDLE.
- Register writes are accepted in every state. Writes to register 0 are ignored.

## Timing
- Reset (rst_n low at an edge): state=IDLE, in_ready=1, out_valid=0, npc=0, taken=0, illegal=0, misaligned=0.
- On reset, reg[i]=i for i<NREG/2 and reg[i]=NREG−i otherwise, with reg[0]=0.
- Reset mid-operation aborts the instruction. No out_valid is produced for it.
- Latency: accept edge → out_valid high 3 cycles later (IDLE→READ→CMP→DONE).
- Throughput: one instruction per 4 cycles with out_ready held high.
- in_ready is high only in IDLE. No input is accepted while a result is pending.
- out_ready low in DONE stalls the unit indefinitely with outputs unchanged.
- out_ready high outside DONE has no effect.

## Configuration
- BRANCH_EXEC_STATS_EN defined: the unit adds output ports br_total[31:0] and br_taken[31:0].
  - br_total increments on each out_valid&out_ready handshake.
  - br_taken increments on each handshake with taken=1.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- Not defined: the ports and counters are absent. All other behaviour is identical.

## Structure
- A shared package branch_pkg holds:
  - the funct3 constants F3_BEQ/F3_BNE/F3_BLT/F3_BGE/F3_BLTU/F3_BGEU
  - the state enum typedef br_state_t
  - the fall-through increment constant PC_STEP=4
- One natural sub-module is branch_cmp: a combinational comparator taking a, b and funct3 and producing taken and illegal. It is instantiated once in CMP.
- The register file and FSM stay in the top module.

## Test plan
- Reset, then BEQ rs1=5, rs2=27 (both 5), imm=8, pc=0x100 → after 3 cycles: out_valid=1, taken=1, npc=0x110, misaligned=0.
- Write reg3=0xFFFF_FFFF_FFFF_FFFF, then BLT rs1=3, rs2=1 → taken=1. Then BLTU with the same operands → taken=0, npc=pc+4.
- BNE rs1=2, rs2=30 (both 2), pc=0xFFFF_FFFC → taken=0, npc=0x0000_0000 (wrap). Then BEQ with imm=0xFFF, pc=0x10 → npc=0xE.
- funct3=010 → illegal=1, taken=0, npc=pc+4. Also taken imm=1, pc=0x0 → npc=0x2, misaligned=1.
- Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0. Same-cycle write reg4=9 during READ of BEQ rs1=4, rs2=9 → taken=1 (forwarding).
- Assert rst_n=0 during CMP → next cycle IDLE, out_valid=0, registers reinitialised. With BRANCH_EXEC_STATS_EN, 3 handshakes with 2 taken → br_total=3, br_taken=2.
